// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
// Default widths, derived counts and FSM state encoding.
package regfile_dump_reader_pkg;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ADDR = 5;
  localparam int DEF_NB_BYTE = 8;

  localparam int NB_BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;
  localparam int N_REGS = 2 ** DEF_NB_ADDR;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_CAPT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    CAPT = ST_CAPT,
    SEND = ST_SEND,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_word_serializer.sv
// Splits one loaded word into bytes, MSB first, over valid/ready.
// last_o pulses in the cycle the final byte handshakes.
module regfile_dump_reader_word_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] data_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [NB_BYTE-1:0] byte_o,
  output logic               last_o
);

  localparam int NBPW = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (NBPW > 1) ? $clog2(NBPW) : 1;

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_o  = 1'b0;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      shift_d = shift_q << NB_BYTE;
      cnt_d   = cnt_q + NB_CNT'(1);
      if (cnt_q == NB_CNT'(NBPW - 1)) begin
        valid_d = 1'b0;
        last_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign byte_o  = shift_q[NB_DATA-1 -: NB_BYTE];

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register address, reads each word and streams it
// out as big-endian bytes toward the debug UART transmitter.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ADDR = DEF_NB_ADDR,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  state_e             st_q, st_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               load;
  logic               last;

  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    load   = 1'b0;
    o_done = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (i_start) begin
          st_d   = REQ;
          addr_d = '0;
        end
      end
      REQ:  st_d = CAPT;
      CAPT: begin
        load = 1'b1;
        st_d = SEND;
      end
      SEND: begin
        if (last) begin
          if (addr_q == '1) begin
            st_d = DONE;
          end else begin
            st_d   = REQ;
            addr_d = addr_q + NB_ADDR'(1);
          end
        end
      end
      DONE: begin
        o_done = 1'b1;
        // A start held through DONE chains straight into the next dump
        if (i_start) begin
          st_d   = REQ;
          addr_d = '0;
        end else begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= IDLE;
      addr_q <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
    end
  end

  assign o_busy    = (st_q != IDLE);
  assign o_rd_addr = addr_q;

  regfile_dump_reader_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .load_i  (load),
    .data_i  (i_rd_data),
    .ready_i (i_tx_ready),
    .valid_o (o_tx_valid),
    .byte_o  (o_tx_data),
    .last_o  (last)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: register-file model, byte queue, monitor.
// Directed scenarios: full dump, stall, restart, abort, chained.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ready;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int nbytes = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  regfile_dump_reader dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (ready)
  );

  always @(posedge clk) rd_data <= 32'hA500_0000 | 32'(rd_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes at the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && ready) begin
        nbytes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte got %h want none", tx_data);
        end else begin
          chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) ndone++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int r = 0; r < 32; r++) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(r));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got 0 want 1");
    end
  endtask

  task automatic wait_cond_timeout(input string name, input logic ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got 0 want 1", name);
    end
  endtask

  task automatic clear_counts();
    nbytes = 0;
    ndone  = 0;
  endtask

  task automatic end_checks(input int want_bytes, input int want_done);
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("nbytes", nbytes, want_bytes);
    chk("ndone", ndone, want_done);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_data", 32'(tx_data), 0);
    rst_n = 1'b1;
    tick();

    // Full dump, no backpressure, with latency checks
    clear_counts();
    push_dump();
    pulse_start();
    chk("req_busy", 32'(busy), 1);
    chk("req_valid", 32'(tx_valid), 0);
    tick();
    chk("capt_valid", 32'(tx_valid), 0);
    tick();
    chk("first_valid", 32'(tx_valid), 1);
    chk("first_byte", 32'(tx_data), 32'hA5);
    cyc = 3;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("done_cycle", cyc, 193);
    end_checks(128, 1);

    // Backpressure on byte 2 of register 3
    clear_counts();
    push_dump();
    pulse_start();
    guard = 0;
    while (!(nbytes == 14 && tx_valid) && guard < 200) begin
      tick();
      guard++;
    end
    wait_cond_timeout("stall_point", nbytes == 14 && tx_valid);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(tx_valid), 1);
      chk("stall_data", 32'(tx_data), 32'h00);
      chk("stall_addr", 32'(rd_addr), 3);
    end
    ready = 1'b1;
    wait_done(cyc);
    end_checks(128, 1);

    // Start pulsed mid-dump at register 10 is ignored
    clear_counts();
    push_dump();
    pulse_start();
    guard = 0;
    while (!(rd_addr == 5'd10 && tx_valid) && guard < 200) begin
      tick();
      guard++;
    end
    wait_cond_timeout("reg10", rd_addr == 5'd10 && tx_valid);
    pulse_start();
    wait_done(cyc);
    end_checks(128, 1);
    repeat (3) tick();
    chk("no_restart", 32'(busy), 0);

    // Asynchronous abort while sending register 7
    clear_counts();
    push_dump();
    pulse_start();
    guard = 0;
    while (!(rd_addr == 5'd7 && tx_valid) && guard < 200) begin
      tick();
      guard++;
    end
    wait_cond_timeout("reg7", rd_addr == 5'd7 && tx_valid);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(tx_valid), 0);
    chk("abort_data", 32'(tx_data), 0);
    chk("abort_addr", 32'(rd_addr), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
    push_dump();
    pulse_start();
    tick();
    tick();
    chk("restart_addr", 32'(rd_addr), 0);
    chk("restart_byte", 32'(tx_data), 32'hA5);
    wait_done(cyc);
    end_checks(128, 1);

    // Start held high: two chained dumps
    clear_counts();
    push_dump();
    push_dump();
    start = 1'b1;
    wait_done(cyc);
    tick();
    chk("chain_busy", 32'(busy), 1);
    chk("chain_done", 32'(done), 0);
    chk("chain_addr", 32'(rd_addr), 0);
    start = 1'b0;
    wait_done(cyc);
    end_checks(256, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
